afft_8: RTL and testbench
=========================

# afft_8

Memory-mapped 8-point complex FFT engine (radix-2, decimation-in-time) acting as a bus master on a simple word-addressed sample memory. On a `start` pulse it fetches eight complex samples from words 0..7, computes the scaled DFT in place in an internal buffer, and presents the eight results while walking words 8..15, optionally flagged as memory writes. It sits beside a host controller that owns the memory and triggers transforms.

## Interface
Parameters: none; point count (8), word addresses and formats are fixed.
- `clk`  in  1  rising-edge clock for all logic.
- `rst_n`  in  1  reset; asynchronous and active-high: the block is held in reset while `rst_n` is 1 and runs while it is 0.
- `start`  in  1  transform trigger; a 0->1 edge seen in IDLE launches one transform.
- `addr`  out  16  `addr[15]` = write strobe, `addr[14:0]` = word address.
- `data_o`  out  32  result word: `[31:16]` real, `[15:0]` imag, signed Q1.15.
- `data_i`  in  32  read data, same format; valid one cycle after the address is issued.
- `we`  in  1  write-back enable; when 1, `addr[15]` is asserted during STORE.
- `req`  in  1  stall request; when 1, the engine freezes.

## Operation
- States: IDLE -> LOAD -> CALC -> STORE -> IDLE.
- Start detect: `start_d` is the registered copy of `start`, reset to 0. A trigger is `start & ~start_d` while in IDLE. Edges in any other state are ignored.
- LOAD: issue addresses 0..7, one per cycle. Capture `data_i` one cycle later into internal buffer index `bitrev3(n)`, where `bitrev3` is 3-bit bit reversal, e.g. x1 -> idx4, x3 -> idx6.
- CALC: 3 stages × 4 butterflies, one butterfly per cycle, in place.
  - Stage s (span 1, 2, 4) pairs `(a, b)` with twiddle `W8^k`, where k = (j mod span) × (4 / span).
  - Butterfly: `a' = (a + bW) >>> 1`, `b' = (a − bW) >>> 1`.
  - Sums use 17-bit intermediates; the shift is arithmetic with truncation.
  - Net scaling: the output is DFT / 8, so overflow is impossible.
- Twiddle multiply:
  - W^0 is bypassed (exact).
  - W^2 = −j is done exactly: (re, im) -> (im, −re).
  - W^1 = c − jc and W^3 = −c − jc use c = 23170 (0x5A82). Each product is a 32-bit signed value >>> 15, truncated, then summed.
- STORE: word k (X[k], natural order) is presented on `data_o` while `addr[14:0] = 8 + k`, for k = 0..7. `addr[15] = we`, sampled each STORE cycle.
- Outside STORE: `addr[15] = 0`. In IDLE, `addr = 0x0000` and `data_o` holds the last STORE value.
- Stall: while `req = 1` in LOAD, CALC or STORE, the following all hold:
  - the state, counters, `addr`, `data_o` and buffer;
  - `data_i` capture is suppressed (the memory keeps returning data for the held address).
  - Processing resumes in the first cycle with `req = 0`. `req` has no effect in IDLE.
- Reset (any time, including mid-transform) aborts to IDLE. `addr = 0`, `data_o = 0`, buffer cleared, `start_d = 0`.

## Timing
- Edge seen at clock edge T0 -> LOAD begins at T0+1 with `addr = 0`.
- LOAD: 9 cycles. Addresses are issued on cycles 1–8; the last capture falls on cycle 9, during which `addr` holds 7.
- CALC: 12 cycles; `addr = 0`.
- STORE: 8 cycles; `addr[14:0] = 8..15`, with `data_o` valid in the same cycle.
- Return to IDLE after STORE. Unstalled total is 29 cycles from LOAD entry to IDLE; each stall cycle adds exactly one.
- A start edge coincident with the final STORE cycle is ignored. A new edge is accepted from the first IDLE cycle.

## Test plan
- Reset: assert `rst_n = 1` for 8 ns asynchronously -> `addr = 0x0000` and `data_o = 0` immediately; state is IDLE.
- Zero run: `data_i = 0`, `we = 0`, `req = 0`, `start` pulsed for 2 cycles -> `addr` steps 0..7, holds 7 for one cycle, then 0 for 12 cycles, then 8..15 with bit 15 clear, `data_o = 0`, then 0. Exactly one transform runs.
- Impulse: x0 = 0x40000000, others 0, `we = 1` -> all eight outputs 0x08000000, with `addr = 0x8008..0x800F`.
- DC: all samples 0x40000000 -> X[0] = 0x40000000, X[1..7] = 0.
- Stall: `req = 1` for 3 cycles mid-CALC and 2 cycles mid-STORE -> results identical to the unstalled run; IDLE is reached 5 cycles later; `addr`/`data_o` frozen during the stalls.
- Abort/ignore: a start edge during CALC is ignored. A reset asserted in STORE -> outputs 0 at once, and the next start gives a correct full transform.

Source files
------------

// File: rtl/afft_8.sv
// afft_8: 8-point radix-2 DIT FFT engine mastering a word-addressed sample memory
module afft_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] addr,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        we,
  input  logic        req
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, STORE} state_t;
  localparam logic signed [15:0] cw = 16'sd23170;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic start_d, last_cnt;
  logic signed [15:0] re [8];
  logic signed [15:0] im [8];
  logic [31:0] held;
  logic [1:0] stage, j, k;
  logic [2:0] ia, ib, n, ld;
  logic signed [31:0] m_re, m_im;
  logic signed [16:0] p1, p2, a_re, a_im, b_re, b_im, w_re, w_im, s_re, s_im, d_re, d_im;
  assign last_cnt = cnt == (state == LOAD ? 4'd8 : state == CALC ? 4'd11 : 4'd7);
  assign addr = state == LOAD ? {13'd0, cnt == 4'd8 ? 3'd7 : cnt[2:0]}
              : state == STORE ? {we, 11'd0, 1'b1, cnt[2:0]} : 16'd0;
  assign data_o = state == STORE ? {re[cnt[2:0]], im[cnt[2:0]]} : held;
  assign n = cnt[2:0] - 3'd1;
  assign ld = {n[0], n[1], n[2]};
  // next-state: launch on a start edge in IDLE, otherwise advance through phases unless stalled
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE) begin
      if (start & ~start_d) begin
        state_nx = LOAD;
        cnt_nx = 4'd0;
      end
    end else if (!req) begin
      cnt_nx = last_cnt ? 4'd0 : cnt + 4'd1;
      if (last_cnt) state_nx = state == LOAD ? CALC : state == CALC ? STORE : IDLE;
    end
  end
  // butterfly operand selection, twiddle multiply and scaled sum/difference
  always_comb begin
    stage = cnt[3:2];
    j = cnt[1:0];
    ia = stage == 2'd0 ? {j, 1'b0} : stage == 2'd1 ? {j[1], 1'b0, j[0]} : {1'b0, j};
    ib = ia | (stage == 2'd0 ? 3'd1 : stage == 2'd1 ? 3'd2 : 3'd4);
    k = stage == 2'd0 ? 2'd0 : stage == 2'd1 ? {j[0], 1'b0} : j;
    a_re = 17'(re[ia]);
    a_im = 17'(im[ia]);
    b_re = 17'(re[ib]);
    b_im = 17'(im[ib]);
    m_re = 32'(re[ib]) * 32'(cw);
    m_im = 32'(im[ib]) * 32'(cw);
    p1 = 17'(m_re >>> 15);
    p2 = 17'(m_im >>> 15);
    w_re = k == 2'd0 ? b_re : k == 2'd1 ? p1 + p2 : k == 2'd2 ? b_im : p2 - p1;
    w_im = k == 2'd0 ? b_im : k == 2'd1 ? p2 - p1 : k == 2'd2 ? -b_re : -p1 - p2;
    s_re = a_re + w_re;
    s_im = a_im + w_im;
    d_re = a_re - w_re;
    d_im = a_im - w_im;
  end
  // state, sample capture in bit-reversed order, in-place butterflies and output hold
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      start_d <= 1'b0;
      held <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        re[i] <= 16'sd0;
        im[i] <= 16'sd0;
      end
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      start_d <= start;
      if (!req && state == LOAD && cnt != 4'd0) begin
        re[ld] <= data_i[31:16];
        im[ld] <= data_i[15:0];
      end
      if (!req && state == CALC) begin
        re[ia] <= 16'(s_re >>> 1);
        im[ia] <= 16'(s_im >>> 1);
        re[ib] <= 16'(d_re >>> 1);
        im[ib] <= 16'(d_im >>> 1);
      end
      if (state == STORE) held <= data_o;
    end
  end
endmodule

// File: tb/tb_afft_8.sv
// tb_afft_8: directed checks of afft_8 timing, arithmetic, stall, ignore and abort behaviour
module tb_afft_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic we = 1'b0;
  logic req = 1'b0;
  logic [15:0] addr;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic [31:0] mem [8];
  logic [31:0] xe [8];
  logic [31:0] last = 32'd0;
  int total = 0;
  int bad = 0;

  afft_8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .addr(addr),
    .data_o(data_o),
    .data_i(data_i),
    .we(we),
    .req(req)
  );

  always #5 clk = ~clk;

  // sample memory with one cycle of read latency
  always @(posedge clk) data_i <= mem[addr[2:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int p);
    return p < 8 ? 16'(p) : p == 8 ? 16'd7 : p < 21 ? 16'd0 : p < 29 ? {we, 15'(p - 13)} : 16'd0;
  endfunction

  // one transform: n1 stall cycles at phase 12 (CALC), n2 at phase 24 (STORE);
  // plen = start pulse length; ign raises start again during CALC; abort_at resets at that phase
  task automatic xf(input int n1, input int n2, input int plen, input bit ign, input int abort_at);
    int p = 0;
    int s1 = n1;
    int s2 = n2;
    logic [31:0] prev = last;
    logic [31:0] ed;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 29 + n1 + n2; i++) begin
      @(negedge clk);
      if (i == plen - 1) start = 1'b0;
      ed = (p >= 21 && p < 29) ? xe[p - 21] : prev;
      chk($sformatf("addr p=%0d", p), {16'd0, addr}, {16'd0, exp_addr(p)});
      chk($sformatf("data p=%0d", p), data_o, ed);
      if (p == abort_at) begin
        #2 rst_n = 1'b1;
        #1 chk("abort_addr", {16'd0, addr}, 32'd0);
        chk("abort_data", data_o, 32'd0);
        rst_n = 1'b0;
        req = 1'b0;
        last = 32'd0;
        return;
      end
      if (ign && p == 15) start = 1'b1;
      if (ign && p == 17) start = 1'b0;
      if (p == 12 && s1 > 0) begin
        req = 1'b1;
        s1--;
      end else if (p == 24 && s2 > 0) begin
        req = 1'b1;
        s2--;
      end else begin
        req = 1'b0;
        p++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_addr", {16'd0, addr}, 32'd0);
      chk("idle_data", data_o, xe[7]);
    end
    last = xe[7];
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    #3 rst_n = 1'b1;
    #1 chk("rst_addr", {16'd0, addr}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    #7 rst_n = 1'b0;
    // zero input, two-cycle start pulse, no write strobe
    xe = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    we = 1'b0;
    xf(0, 0, 2, 1'b0, -1);
    // impulse at x0 with write strobe
    mem[0] = 32'h40000000;
    for (int i = 0; i < 8; i++) xe[i] = 32'h08000000;
    we = 1'b1;
    xf(0, 0, 1, 1'b0, -1);
    // DC input
    for (int i = 0; i < 8; i++) mem[i] = 32'h40000000;
    xe = '{32'h40000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    we = 1'b0;
    xf(0, 0, 1, 1'b0, -1);
    // real impulse at x1 exercises every twiddle
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    mem[1] = 32'h40000000;
    xe = '{32'h08000000, 32'h05A8FA58, 32'h0000F800, 32'hFA58FA58,
           32'hF8000000, 32'hFA5805A8, 32'h00000800, 32'h05A805A8};
    xf(0, 0, 1, 1'b0, -1);
    // same with stalls in CALC and STORE plus an ignored start edge during CALC
    xf(3, 2, 1, 1'b1, -1);
    // reset during STORE
    xf(0, 0, 1, 1'b0, 23);
    // imaginary impulse at x1 after the abort
    mem[1] = 32'h00004000;
    xe = '{32'h00000800, 32'h05A805A8, 32'h08000000, 32'h05A8FA58,
           32'h0000F800, 32'hFA58FA58, 32'hF8000000, 32'hFA5805A8};
    we = 1'b1;
    xf(0, 0, 1, 1'b0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
